// File: rtl/const_load_sequencer_if.sv
// const_load_sequencer_if: request/instruction handshake bundle for const_load_sequencer
//   request side : i_req_valid, o_req_ready, i_value[31:0], i_rt[4:0]
//   instr side   : o_instr_valid, i_instr_ready, o_instr[31:0], o_instr_last
//   status       : o_busy, o_count[CNT_W-1:0], o_mismatch
interface const_load_sequencer_if #(parameter int CNT_W = 16);
  logic i_req_valid;
  logic o_req_ready;
  logic [31:0] i_value;
  logic [4:0] i_rt;
  logic o_instr_valid;
  logic i_instr_ready;
  logic [31:0] o_instr;
  logic o_instr_last;
  logic o_busy;
  logic [CNT_W-1:0] o_count;
  logic o_mismatch;
  modport master(
    output i_req_valid, i_value, i_rt, i_instr_ready,
    input o_req_ready, o_instr_valid, o_instr, o_instr_last, o_busy, o_count, o_mismatch
  );
  modport slave(
    input i_req_valid, i_value, i_rt, i_instr_ready,
    output o_req_ready, o_instr_valid, o_instr, o_instr_last, o_busy, o_count, o_mismatch
  );
endinterface

// File: rtl/const_load_sequencer.sv
// const_load_sequencer: emits the shortest ADDIU/ORI/LUI sequence that loads a 32-bit constant
//   i_clk, i_rst_n (async active-low); bus (slave modport of const_load_sequencer_if)
//   optional CONST_LOAD_SELF_CHECK_EN: models the extended register result and flags a sticky o_mismatch
module const_load_sequencer #(parameter int CNT_W = 16) (
  input logic i_clk,
  input logic i_rst_n,
  const_load_sequencer_if.slave bus
);
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] LUI = 6'b001111;
  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
  state_t state;
  logic pair;
  logic [4:0] rt;
  logic [15:0] lo;
  logic sext, zext, hi, single;
  logic [31:0] first;
  assign sext = &bus.i_value[31:15] | ~|bus.i_value[31:15];
  assign zext = ~|bus.i_value[31:16];
  assign hi = ~|bus.i_value[15:0];
  assign single = sext | zext | hi;
  assign first = sext ? {ADDIU, 5'd0, bus.i_rt, bus.i_value[15:0]} :
                 zext ? {ORI, 5'd0, bus.i_rt, bus.i_value[15:0]} :
                        {LUI, 5'd0, bus.i_rt, bus.i_value[31:16]};
  assign bus.o_req_ready = i_rst_n && state == IDLE;
  assign bus.o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      pair <= 1'b0;
      rt <= '0;
      lo <= '0;
      bus.o_instr <= '0;
      bus.o_instr_valid <= 1'b0;
      bus.o_instr_last <= 1'b0;
      bus.o_count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.i_req_valid) begin
          rt <= bus.i_rt;
          lo <= bus.i_value[15:0];
          pair <= !single;
          bus.o_instr <= first;
          bus.o_instr_valid <= 1'b1;
          bus.o_instr_last <= single;
          state <= EMIT1;
        end
        EMIT1: if (bus.i_instr_ready) begin
          bus.o_count <= bus.o_count + 1'b1;
          if (pair) begin
            bus.o_instr <= {ORI, rt, rt, lo};
            bus.o_instr_last <= 1'b1;
            state <= EMIT2;
          end else begin
            bus.o_instr_valid <= 1'b0;
            bus.o_instr_last <= 1'b0;
            state <= IDLE;
          end
        end
        EMIT2: if (bus.i_instr_ready) begin
          bus.o_count <= bus.o_count + 1'b1;
          bus.o_instr_valid <= 1'b0;
          bus.o_instr_last <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONST_LOAD_SELF_CHECK_EN
  logic [31:0] val, acc, model;
  logic [15:0] imm;
  logic [5:0] op;
  logic hs, mism;
  assign hs = bus.o_instr_valid & bus.i_instr_ready;
  assign op = bus.o_instr[31:26];
  assign imm = bus.o_instr[15:0];
  // The second word always chains on the first, so it ORs onto the accumulated value
  // rather than honouring rs, which keeps rt=0 pairs from reading a hardwired zero.
  always_comb begin
    model = op == ADDIU ? {{16{imm[15]}}, imm} :
            op == LUI ? {imm, 16'h0} :
            ((state == EMIT2 ? acc : 32'h0) | {16'h0, imm});
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      val <= '0;
      acc <= '0;
      mism <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_req_valid) val <= bus.i_value;
      if (hs) acc <= model;
      if (hs && bus.o_instr_last && model != val) mism <= 1'b1;
    end
  end
  assign bus.o_mismatch = mism;
`else
  assign bus.o_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_const_load_sequencer.sv
// tb_const_load_sequencer: directed and randomised checks of const_load_sequencer
module tb_const_load_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;
  const_load_sequencer_if #(.CNT_W(16)) bus();
  const_load_sequencer #(.CNT_W(16)) dut(.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] v, input logic [4:0] r);
    bus.i_req_valid = 1'b1;
    bus.i_value = v;
    bus.i_rt = r;
    tick();
    bus.i_req_valid = 1'b0;
    bus.i_value = $urandom;
    bus.i_rt = 5'($urandom);
  endtask
  task automatic single(input string tag, input logic [31:0] v, input logic [4:0] r, input logic [31:0] exp);
    bus.i_instr_ready = 1'b1;
    send(v, r);
    check({tag, "_instr"}, bus.o_instr, exp);
    check({tag, "_last"}, bus.o_instr_last, 1);
    check({tag, "_valid"}, bus.o_instr_valid, 1);
    check({tag, "_busy_ready"}, {bus.o_busy, bus.o_req_ready}, 2'b10);
    tick();
    exp_cnt++;
    check({tag, "_count"}, bus.o_count, exp_cnt);
    check({tag, "_done"}, {bus.o_instr_valid, bus.o_req_ready}, 2'b01);
  endtask
  task automatic pair(input string tag, input logic [31:0] v, input logic [4:0] r,
                      input logic [31:0] w0, input logic [31:0] w1, input int stall);
    bus.i_instr_ready = 1'b0;
    send(v, r);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_hold_instr"}, bus.o_instr, w0);
      check({tag, "_hold_last"}, {bus.o_instr_valid, bus.o_instr_last}, 2'b10);
      tick();
    end
    check({tag, "_w0"}, bus.o_instr, w0);
    bus.i_instr_ready = 1'b1;
    tick();
    exp_cnt++;
    check({tag, "_w1"}, bus.o_instr, w1);
    check({tag, "_w1_last"}, {bus.o_instr_valid, bus.o_instr_last}, 2'b11);
    check({tag, "_cnt1"}, bus.o_count, exp_cnt);
    tick();
    exp_cnt++;
    check({tag, "_cnt2"}, bus.o_count, exp_cnt);
    check({tag, "_end"}, {bus.o_instr_valid, bus.o_req_ready}, 2'b01);
  endtask
  function automatic void enc(input logic [31:0] v, input logic [4:0] r,
                              output logic [31:0] w0, output logic [31:0] w1, output int n);
    w1 = '0;
    n = 1;
    if (v[31:15] == '0 || v[31:15] == '1) w0 = {6'h09, 5'd0, r, v[15:0]};
    else if (v[31:16] == '0) w0 = {6'h0d, 5'd0, r, v[15:0]};
    else if (v[15:0] == '0) w0 = {6'h0f, 5'd0, r, v[31:16]};
    else begin
      w0 = {6'h0f, 5'd0, r, v[31:16]};
      w1 = {6'h0d, r, r, v[15:0]};
      n = 2;
    end
  endfunction
  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_value = '0;
    bus.i_rt = '0;
    bus.i_instr_ready = 1'b0;
    #12;
    check("rst_outputs", {bus.o_instr_valid, bus.o_instr_last, bus.o_busy, bus.o_mismatch}, 4'b0);
    check("rst_instr", bus.o_instr, 32'h0);
    check("rst_count", bus.o_count, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", bus.o_req_ready, 1);
    single("sext", 32'h0000_1234, 5'd5, 32'h2405_1234);
    single("zext", 32'h0000_8000, 5'd5, 32'h3405_8000);
    single("sext_neg", 32'hFFFF_8000, 5'd5, 32'h2405_8000);
    single("sext_max", 32'h0000_7FFF, 5'd5, 32'h2405_7FFF);
    single("hi", 32'h1234_0000, 5'd8, 32'h3C08_1234);
    single("zero", 32'h0, 5'd0, 32'h2400_0000);
    pair("pair", 32'h1234_5678, 5'd8, 32'h3C08_1234, 32'h3508_5678, 3);
    pair("pair_neg", 32'hFFFF_7FFF, 5'd5, 32'h3C05_FFFF, 32'h34A5_7FFF, 0);
    pair("pair_r0", 32'h0001_0001, 5'd0, 32'h3C00_0001, 32'h3400_0001, 1);
    bus.i_instr_ready = 1'b1;
    send(32'h1234_5678, 5'd8);
    tick();
    check("emit2_w1", bus.o_instr, 32'h3508_5678);
    rst_n = 1'b0;
    #1;
    check("abort_flags", {bus.o_instr_valid, bus.o_instr_last, bus.o_busy, bus.o_req_ready}, 4'b0);
    check("abort_instr", bus.o_instr, 32'h0);
    check("abort_count", bus.o_count, 32'h0);
    exp_cnt = '0;
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_ready", {bus.o_req_ready, bus.o_instr_valid}, 2'b10);
    tick();
    single("after_abort", 32'hFFFF_FFFF, 5'd1, 32'h2401_FFFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    tick();
    for (int t = 0; t < 1000; t++) begin
      logic [31:0] v, w0, w1, w;
      logic [4:0] r;
      int n, g;
      logic rdy;
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = {16'h0, 16'($urandom)};
        2: v = {16'hFFFF, 1'b1, 15'($urandom)};
        default: v = {16'($urandom), 16'h0};
      endcase
      r = 5'($urandom);
      enc(v, r, w0, w1, n);
      g = 0;
      while (!bus.o_req_ready && g < 20) begin
        tick();
        g++;
      end
      if (g >= 20) check("rnd_ready_timeout", 0, 1);
      bus.i_instr_ready = 1'b0;
      send(v, r);
      for (int k = 0; k < n; k++) begin
        w = k == 0 ? w0 : w1;
        g = 0;
        do begin
          rdy = g > 8 ? 1'b1 : 1'($urandom_range(0, 1));
          if (rdy) begin
            check("rnd_instr", bus.o_instr, w);
            check("rnd_last_valid", {bus.o_instr_valid, bus.o_instr_last}, {1'b1, k == n - 1});
          end
          bus.i_instr_ready = rdy;
          tick();
          g++;
        end while (!rdy);
        exp_cnt++;
      end
      bus.i_instr_ready = 1'b0;
    end
    check("rnd_count", bus.o_count, exp_cnt);
    check("rnd_mismatch", bus.o_mismatch, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/const_load_sequencer.md
Name: const_load_sequencer

Overview:
- Inverse of the datapath's immediate extension. Takes a 32-bit constant and a destination register and emits the shortest MIPS instruction sequence (1 or 2 words) that loads that constant.
- Each emitted immediate, once passed through the core's zero/sign/lui extension, reproduces the constant.
- Sits in the debug/boot instruction-injection path, ahead of the instruction-memory writer or the IF-stage injection mux.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  block can accept a request.
- i_value  input  32  constant to load.
- i_rt  input  5  destination register number.
- o_instr_valid  output  1  o_instr holds a valid instruction word.
- i_instr_ready  input  1  downstream accepts o_instr this cycle.
- o_instr  output  32  encoded instruction {op[5:0], rs[4:0], rt[4:0], imm[15:0]}.
- o_instr_last  output  1  current word is the last of its sequence.
- o_busy  output  1  state is not IDLE.
- o_count  output  CNT_W  total instruction words handed off.
- o_mismatch  output  1  sticky self-check error (see Optional Feature).

Behaviour:
- Reset: state=IDLE.
  - o_instr_valid=0, o_instr=0, o_instr_last=0, o_busy=0, o_count=0, o_mismatch=0.
  - o_req_ready=1 once reset is released.
  - Asserting reset mid-sequence aborts it; no partial word is reported afterwards.
- Opcodes: ADDIU=6'b001001, ORI=6'b001101, LUI=6'b001111.
- Encoding classes are checked in priority order; the first match wins:
  - SEXT, when i_value[31:15] is all 0 or all 1: one word, ADDIU rt,$0,value[15:0].
  - ZEXT, when value[31:16]==0: one word, ORI rt,$0,value[15:0].
  - HI, when value[15:0]==0: one word, LUI rt,value[31:16] (rs=0).
  - PAIR, otherwise: LUI rt,value[31:16], then ORI rt,rt,value[15:0].
- Boundary cases:
  - value=0 encodes as ADDIU rt,$0,0.
  - i_rt=0 is still encoded and emitted; no suppression.
- States: IDLE, EMIT1, EMIT2.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid: latch value and rt, classify, and load the first word into the o_instr register.
  - Set o_instr_valid=1, with o_instr_last=1 for every class except PAIR.
  - Go to EMIT1.
- EMIT1:
  - o_req_ready=0.
  - Hold o_instr, o_instr_valid and o_instr_last stable until i_instr_ready=1.
  - On the handshake, o_count increments (wraps at 2^CNT_W).
  - PAIR: load the ORI word, set last=1, go to EMIT2.
  - All other classes: drop valid and go to IDLE.
- EMIT2:
  - Hold the ORI word until the handshake.
  - On the handshake, o_count increments, valid drops and state goes to IDLE.
- Latency and throughput:
  - A request accepted at edge N shows the first word valid after edge N.
  - With i_instr_ready held at 1, a single-word class takes 2 cycles from accept to the next accept; PAIR takes 3.
  - The block never accepts a new request in the same cycle as a final handshake.
- i_instr_ready while o_instr_valid=0 is ignored.
- i_value and i_rt are don't-care outside the IDLE accept cycle.

Optional Feature:
- Macro: CONST_LOAD_SELF_CHECK_EN.
- When defined:
  - The block models the register result of each emitted word using core extension semantics: ADDIU sign-extends, ORI zero-extends and ORs, LUI shifts the immediate left by 16.
  - On the last handshake, o_mismatch is set sticky if the modelled value differs from the latched value.
  - Only reset clears o_mismatch.
- When undefined:
  - o_mismatch is tied 0 and the model logic is absent.

Test Plan:
- value=0x00001234, rt=5, ready=1 -> single word 0x24051234, last=1; o_count 0→1; o_req_ready back to 1 two cycles after accept.
- value=0x00008000, rt=5 -> 0x34058000 (ZEXT). value=0xFFFF8000, rt=5 -> 0x24058000 (SEXT wins).
- value=0x12340000, rt=8 -> single word 0x3C081234, last=1.
- value=0x12345678, rt=8, ready held low 3 cycles:
  - 0x3C081234 is held stable with last=0 throughout.
  - After the handshake, 0x35085678 follows with last=1.
  - o_count increases by 2.
- Reset asserted in EMIT2 -> all outputs 0 immediately, o_req_ready=1 after release; a next request of 0xFFFFFFFF, rt=1 yields 0x2401FFFF.
- CONST_LOAD_SELF_CHECK_EN defined, random 1000 values/rt with random ready -> o_mismatch stays 0; o_count equals the number of words handed off.
